// File: rtl/adder_check_pkg.sv
// Shared definitions for the adder response checker: FSM encoding, defaults
// and the reference addition used to form the expected response.
package adder_check_pkg;

  localparam int ADD_CNT_W_DEF  = 8;
  localparam int ADD_SETTLE_DEF = 2;
  localparam int ADD_MAX_W      = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Full-width sum of two operands and a carry-in; callers keep the low WIDTH+1 bits.
  function automatic logic [ADD_MAX_W:0] exp_add(input logic [ADD_MAX_W-1:0] a,
                                                 input logic [ADD_MAX_W-1:0] b,
                                                 input logic                 cin);
    return {1'b0, a} + {1'b0, b} + {{ADD_MAX_W{1'b0}}, cin};
  endfunction

endpackage

// File: rtl/adder_check_if.sv
// Stimulus/response bundle between the adder test driver and the checker.
interface adder_check_if
  import adder_check_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = ADD_CNT_W_DEF
);
  logic             vld;
  logic             last;
  logic             rdy;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic [CNT_W-1:0] vec_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic             err_flag;
  logic [2*WIDTH:0] first_err;
  logic             done;
  logic             pass;

  modport master (
    output vld, last, a, b, cin, sum, cout,
    input  rdy, vec_cnt, err_cnt, err_flag, first_err, done, pass
  );

  modport slave (
    input  vld, last, a, b, cin, sum, cout,
    output rdy, vec_cnt, err_cnt, err_flag, first_err, done, pass
  );
endinterface

// File: rtl/adder_check_sat_cnt.sv
// Generic up-counter with synchronous clear; SAT selects saturate-at-all-ones
// instead of wrapping.
module sat_cnt #(
  parameter int W   = 8,
  parameter bit SAT = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !(SAT && (&cnt_q))) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/adder_check.sv
// Response checker for an adder under test: captures operands, waits SETTLE
// cycles, compares {cout,sum} with the exact sum and keeps counts and a verdict.
module adder_check
  import adder_check_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int SETTLE = ADD_SETTLE_DEF,
  parameter int CNT_W  = ADD_CNT_W_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  adder_check_if.slave  bus
);
  localparam int SW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int OPW = 2 * WIDTH + 1;

  state_t             state_q;
  logic [SW-1:0]      settle_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               cin_q;
  logic               last_q;
  logic [WIDTH:0]     exp_q;
  logic               rdy_q;
  logic               done_q;
  logic               pass_q;
  logic               err_flag_q;
  logic [OPW-1:0]     first_err_q;

  logic [ADD_MAX_W:0] exp_full;
  logic               sample;
  logic               mismatch;

  assign exp_full = exp_add(ADD_MAX_W'(bus.a), ADD_MAX_W'(bus.b), bus.cin);

  // Upper bits of the wide reference sum are always zero for WIDTH-bit operands.
  generate
    if (WIDTH < ADD_MAX_W) begin : g_unused_hi
      logic unused_exp_hi;
      assign unused_exp_hi = ^exp_full[ADD_MAX_W:WIDTH+1];
    end
  endgenerate

  assign sample   = (state_q == ST_WAIT) && (settle_q == '0);
  assign mismatch = sample && ({bus.cout, bus.sum} != exp_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      settle_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      last_q      <= 1'b0;
      exp_q       <= '0;
      rdy_q       <= 1'b1;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_flag_q  <= 1'b0;
      first_err_q <= '0;
    end else if (clr) begin
      state_q     <= ST_IDLE;
      settle_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      last_q      <= 1'b0;
      exp_q       <= '0;
      rdy_q       <= 1'b1;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_flag_q  <= 1'b0;
      first_err_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.vld) begin
            a_q      <= bus.a;
            b_q      <= bus.b;
            cin_q    <= bus.cin;
            last_q   <= bus.last;
            exp_q    <= exp_full[WIDTH:0];
            settle_q <= SW'(SETTLE - 1);
            rdy_q    <= 1'b0;
            state_q  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (settle_q != '0) begin
            settle_q <= settle_q - SW'(1);
          end else begin
            if (mismatch) begin
              err_flag_q <= 1'b1;
              if (!err_flag_q) begin
                first_err_q <= {a_q, b_q, cin_q};
              end
            end
            // A nonzero error count always coincides with err_flag, so pass keys off the flag.
            if (last_q) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              pass_q  <= !(err_flag_q || mismatch);
            end else begin
              state_q <= ST_IDLE;
              rdy_q   <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_DONE;
        end
        default: begin
          state_q <= ST_IDLE;
          rdy_q   <= 1'b1;
        end
      endcase
    end
  end

  sat_cnt #(.W(CNT_W), .SAT(1'b0)) u_vec_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (clr),
    .inc_i (sample),
    .cnt_o (bus.vec_cnt)
  );

  sat_cnt #(.W(CNT_W), .SAT(1'b1)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (clr),
    .inc_i (mismatch),
    .cnt_o (bus.err_cnt)
  );

  assign bus.rdy       = rdy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_flag  = err_flag_q;
  assign bus.first_err = first_err_q;
endmodule

// File: tb/tb_adder_check.sv
// Bench for adder_check: two instances (1-bit/SETTLE=2/CNT_W=8 and
// 4-bit/SETTLE=1/CNT_W=2) checked against a counting scoreboard.
module tb_adder_check;

  logic clk = 1'b0;
  logic rst_n;
  logic clr_a;
  logic clr_b;

  always #5 clk = ~clk;

  adder_check_if #(.WIDTH(1), .CNT_W(8)) if_a ();
  adder_check_if #(.WIDTH(4), .CNT_W(2)) if_b ();

  adder_check #(.WIDTH(1), .SETTLE(2), .CNT_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .clr(clr_a), .bus(if_a.slave)
  );
  adder_check #(.WIDTH(4), .SETTLE(1), .CNT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(clr_b), .bus(if_b.slave)
  );

  int n_err = 0;
  int n_chk = 0;
  int w_of[2]  = '{1, 4};
  int st_of[2] = '{2, 1};
  int cw_of[2] = '{8, 2};

  // Scoreboard: what each checker should report, derived from the vectors sent.
  int m_vec[2];
  int m_err[2];
  int m_ferr[2];
  bit m_flag[2];
  bit m_done[2];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset(input int s);
    m_vec[s]  = 0;
    m_err[s]  = 0;
    m_ferr[s] = 0;
    m_flag[s] = 1'b0;
    m_done[s] = 1'b0;
  endtask

  task automatic drive(input int s, input bit vld, input bit last,
                       input int a, input int b, input int cin, input int resp);
    if (s == 0) begin
      if_a.vld = vld; if_a.last = last; if_a.a = a[0]; if_a.b = b[0]; if_a.cin = cin[0];
      if_a.sum = resp[0]; if_a.cout = resp[1];
    end else begin
      if_b.vld = vld; if_b.last = last; if_b.a = a[3:0]; if_b.b = b[3:0]; if_b.cin = cin[0];
      if_b.sum = resp[3:0]; if_b.cout = resp[4];
    end
  endtask

  task automatic set_vld(input int s, input bit v);
    if (s == 0) if_a.vld = v;
    else        if_b.vld = v;
  endtask

  task automatic observe(input int s, output logic [31:0] rdy, output logic [31:0] vec,
                         output logic [31:0] err, output logic [31:0] flag,
                         output logic [31:0] ferr, output logic [31:0] done,
                         output logic [31:0] pass);
    if (s == 0) begin
      rdy = 32'(if_a.rdy); vec = 32'(if_a.vec_cnt); err = 32'(if_a.err_cnt);
      flag = 32'(if_a.err_flag); ferr = 32'(if_a.first_err);
      done = 32'(if_a.done); pass = 32'(if_a.pass);
    end else begin
      rdy = 32'(if_b.rdy); vec = 32'(if_b.vec_cnt); err = 32'(if_b.err_cnt);
      flag = 32'(if_b.err_flag); ferr = 32'(if_b.first_err);
      done = 32'(if_b.done); pass = 32'(if_b.pass);
    end
  endtask

  task automatic check_outputs(input int s, input string tag);
    logic [31:0] rdy, vec, err, flag, ferr, done, pass;
    observe(s, rdy, vec, err, flag, ferr, done, pass);
    check_val({tag, "_rdy"},   rdy,  32'(!m_done[s]));
    check_val({tag, "_vec"},   vec,  32'(m_vec[s]));
    check_val({tag, "_err"},   err,  32'(m_err[s]));
    check_val({tag, "_flag"},  flag, 32'(m_flag[s]));
    check_val({tag, "_ferr"},  ferr, 32'(m_ferr[s]));
    check_val({tag, "_done"},  done, 32'(m_done[s]));
    check_val({tag, "_pass"},  pass, 32'(m_done[s] && (m_err[s] == 0)));
  endtask

  task automatic get_one(input int s, input int which, output logic [31:0] v);
    logic [31:0] o[7];
    observe(s, o[0], o[1], o[2], o[3], o[4], o[5], o[6]);
    v = o[which];
  endtask

  // fault: 0 = correct adder, 1 = cout stuck at 0, 2 = corrupted response.
  // Called at a falling edge; returns at the falling edge where results are visible.
  task automatic send(input int s, input int a, input int b, input int cin,
                      input bit last, input int fault, input string tag);
    int exp_v, resp, n, w, lim;
    logic [31:0] rdy;
    w     = w_of[s];
    exp_v = a + b + cin;
    case (fault)
      1:       resp = exp_v & ~(1 << w);
      2:       resp = exp_v ^ int'($urandom_range(1, (1 << (w + 1)) - 1));
      default: resp = exp_v;
    endcase
    n = 0;
    get_one(s, 0, rdy);
    while (rdy !== 32'd1 && n < 50) begin
      @(negedge clk);
      n++;
      get_one(s, 0, rdy);
    end
    if (rdy !== 32'd1) begin
      check_val({tag, "_rdy_timeout"}, rdy, 32'd1);
      return;
    end
    drive(s, 1'b1, last, a, b, cin, resp);
    @(negedge clk);
    set_vld(s, 1'b0);
    get_one(s, 0, rdy);
    check_val({tag, "_wait_rdy"}, rdy, 32'd0);
    for (int k = 1; k < st_of[s]; k++) begin
      @(negedge clk);
      get_one(s, 0, rdy);
      check_val({tag, "_wait_rdy"}, rdy, 32'd0);
    end
    @(negedge clk);
    lim = (1 << cw_of[s]) - 1;
    m_vec[s] = (m_vec[s] + 1) % (1 << cw_of[s]);
    if (resp != exp_v) begin
      if (m_err[s] < lim) m_err[s]++;
      if (!m_flag[s]) m_ferr[s] = (a << (w + 1)) | (b << 1) | cin;
      m_flag[s] = 1'b1;
    end
    if (last) m_done[s] = 1'b1;
    check_outputs(s, tag);
    $display("txn %s dut=%0d a=%0d b=%0d cin=%0d resp=%0h exp=%0h last=%0d vec=%0d err=%0d",
             tag, s, a, b, cin, resp, exp_v, last, m_vec[s], m_err[s]);
  endtask

  task automatic do_clr(input int s);
    if (s == 0) clr_a = 1'b1;
    else        clr_b = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    clr_b = 1'b0;
    model_reset(s);
    check_outputs(s, "clr");
  endtask

  task automatic run_exhaustive(input int fault, input string tag);
    for (int v = 0; v < 8; v++) begin
      send(0, (v >> 2) & 1, (v >> 1) & 1, v & 1, v == 7, fault, tag);
    end
  endtask

  initial begin
    logic [31:0] val;
    int r_a, r_b, r_c, n_vec;

    rst_n = 1'b0;
    clr_a = 1'b0;
    clr_b = 1'b0;
    drive(0, 1'b0, 1'b0, 0, 0, 0, 0);
    drive(1, 1'b0, 1'b0, 0, 0, 0, 0);
    model_reset(0);
    model_reset(1);
    repeat (3) @(negedge clk);
    check_outputs(0, "rst");
    check_outputs(1, "rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Exhaustive 1-bit vectors against a correct adder.
    run_exhaustive(0, "exh");
    get_one(0, 1, val); check_val("exh_vec8", val, 32'd8);
    get_one(0, 6, val); check_val("exh_pass1", val, 32'd1);

    // Same vectors with cout stuck at 0: 011,101,110,111 fail.
    do_clr(0);
    run_exhaustive(1, "stuck");
    get_one(0, 2, val); check_val("stuck_err4", val, 32'd4);
    get_one(0, 4, val); check_val("stuck_ferr", val, 32'b011);
    get_one(0, 6, val); check_val("stuck_pass0", val, 32'd0);

    // vld held high: acceptance every SETTLE+1 = 3 cycles.
    do_clr(0);
    drive(0, 1'b1, 1'b0, 1, 1, 0, 2);
    for (int c = 0; c <= 12; c++) begin
      get_one(0, 0, val);
      check_val("hold_rdy", val, 32'((c % 3) == 0));
      if (c < 12) @(negedge clk);
    end
    set_vld(0, 1'b0);
    m_vec[0] = 4;
    check_outputs(0, "hold");

    // Reset in the middle of WAIT on vector 5.
    do_clr(0);
    for (int v = 0; v < 5; v++) send(0, (v >> 2) & 1, (v >> 1) & 1, v & 1, 1'b0, 0, "pre");
    drive(0, 1'b1, 1'b0, 1, 0, 1, 2);
    @(negedge clk);
    set_vld(0, 1'b0);
    rst_n = 1'b0;
    #1;
    model_reset(0);
    model_reset(1);
    check_outputs(0, "rstw_hold");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    get_one(0, 0, val);
    check_val("rstw_rdy", val, 32'd1);
    @(negedge clk);
    check_outputs(0, "rstw_rel");
    run_exhaustive(0, "rerun");
    get_one(0, 1, val); check_val("rerun_vec8", val, 32'd8);

    // Random vectors with random faults on the 1-bit checker.
    do_clr(0);
    for (int i = 0; i < 30; i++) begin
      send(0, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
           i == 29, (int'($urandom_range(0, 3)) == 0) ? int'($urandom_range(1, 2)) : 0, "rnda");
    end

    // 4-bit, SETTLE=1: 15+1+1 = 5'b10001, completes with done the cycle after.
    send(1, 15, 1, 1, 1'b1, 0, "w4");
    get_one(1, 6, val); check_val("w4_pass1", val, 32'd1);
    // vld in DONE must be ignored.
    drive(1, 1'b1, 1'b1, 3, 4, 0, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_outputs(1, "done_ign");
    end
    set_vld(1, 1'b0);

    // CNT_W=2: five failing vectors saturate err_cnt at 3, vec_cnt wraps to 1.
    do_clr(1);
    for (int i = 0; i < 5; i++) begin
      send(1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 1)), 1'b0, 2, "sat");
    end
    get_one(1, 2, val); check_val("sat_err3", val, 32'd3);
    get_one(1, 1, val); check_val("sat_vec1", val, 32'd1);

    // clr during WAIT discards the in-flight vector.
    do_clr(1);
    drive(1, 1'b1, 1'b0, 7, 9, 1, 0);
    @(negedge clk);
    set_vld(1, 1'b0);
    clr_b = 1'b1;
    @(negedge clk);
    clr_b = 1'b0;
    check_outputs(1, "clrw");

    // Random 4-bit traffic with wrap/saturation in play.
    n_vec = 40;
    for (int i = 0; i < n_vec; i++) begin
      r_a = int'($urandom_range(0, 15));
      r_b = int'($urandom_range(0, 15));
      r_c = int'($urandom_range(0, 1));
      send(1, r_a, r_b, r_c, i == n_vec - 1,
           ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 2)) : 0, "rndb");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/adder_check.md
# adder_check

Synthesizable response checker for the full/ripple adder test flow. The stimulus side drives operands into the adder under test. This block receives the same operands plus the adder's sum/carry, waits a programmable settle time, and compares against an internally computed expected value. It then accumulates vector/error counts and a pass/fail verdict. It sits beside the adder under test, on the response end of the stimulus/response interface.

## Interface
- WIDTH, 1: operand width; 1 gives a single full adder.
- SETTLE, 2: cycles between operand acceptance and response sampling; legal range ≥1.
- CNT_W, 8: width of vector and error counters.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear of all state; returns the block to IDLE.
- vld  in  1  operands a/b/cin are being applied to the DUT this cycle.
- last  in  1  qualifies vld; marks the final vector.
- rdy  out  1  high only in IDLE; a vector is accepted when vld&&rdy.
- a  in  WIDTH  operand A as driven to the DUT.
- b  in  WIDTH  operand B as driven to the DUT.
- cin  in  1  carry-in as driven to the DUT.
- sum  in  WIDTH  DUT sum output.
- cout  in  1  DUT carry-out.
- vec_cnt  out  CNT_W  number of vectors checked; wraps.
- err_cnt  out  CNT_W  number of mismatches; saturates at all-ones.
- err_flag  out  1  sticky; set on the first mismatch.
- first_err  out  2*WIDTH+1  {a,b,cin} of the first mismatching vector.
- done  out  1  the last vector has been checked.
- pass  out  1  done && err_cnt==0.

## Operation
- FSM has three states: IDLE, WAIT, DONE.
- IDLE:
  - On vld&&rdy, register a, b, cin and last.
  - Register exp = a+b+cin, computed at WIDTH+1 bits with no truncation.
  - Load the settle counter with SETTLE-1 and go to WAIT.
- WAIT:
  - Decrement the settle counter each cycle.
  - When the counter is 0, sample {cout,sum} and compare it to exp.
  - Increment vec_cnt.
  - On mismatch:
    - Increment err_cnt, saturating.
    - If err_flag was 0, load first_err with the registered operands.
    - Set err_flag.
  - Next state is DONE if the registered last is 1, otherwise IDLE.
- DONE:
  - rdy=0; vld is ignored.
  - done=1 and pass are held.
  - Exits only via clr or rst_n.
- clr has priority over all FSM activity. Its effect is identical to reset, but synchronous.
- Inputs vld, last, a, b and cin are ignored outside IDLE.

## Timing
- Reset values:
  - state=IDLE, rdy=1.
  - vec_cnt=0, err_cnt=0, err_flag=0, first_err=0.
  - done=0, pass=0.
- Acceptance happens at the edge ending cycle T.
- The block is in WAIT during cycles T+1..T+SETTLE.
- sum/cout are sampled at the edge ending cycle T+SETTLE.
- Counters and flags are visible from cycle T+SETTLE+1. In that cycle rdy=1, or done=1 if last.
- Maximum throughput is one vector per SETTLE+1 cycles. vld held high is accepted every SETTLE+1 cycles.
- The DUT must hold its operands stable until sampling. This is the stimulus side's responsibility.
- err_cnt saturation has no effect on vec_cnt.
- vec_cnt wraps from 2^CNT_W-1 to 0.
- Reset or clr asserted during WAIT:
  - The in-flight vector is discarded and no count is taken.
  - After reset, rdy is high from the first cycle after rst_n deasserts. After clr, rdy is high the cycle after.
- vld&&last with SETTLE=1 completes at T+1 and is done in cycle T+2.

## Structure
- Shared package/header adder_check_pkg holds:
  - the state encodings (IDLE/WAIT/DONE);
  - the function exp_add(a,b,cin), returning WIDTH+1 bits;
  - the default CNT_W and SETTLE values.
- Sub-module sat_cnt(W, SAT) is a generic counter with clear and a saturate-enable parameter. It is instantiated twice: wrapping for vec_cnt, saturating for err_cnt.
- The FSM, settle counter and capture registers live in the top level.

## Test plan
- Exhaustive 8 full-adder vectors with a correct DUT (WIDTH=1, SETTLE=2), last on vector 111. Required: vec_cnt=8, err_cnt=0, done=1, pass=1.
- Same 8 vectors with DUT cout stuck at 0. Required: err_cnt=4, err_flag=1, first_err=3'b011, pass=0.
- vld held high continuously with SETTLE=2. Required: acceptances every 3 cycles, rdy low for exactly 2 cycles after each.
- Reset pulse in the middle of WAIT on vector 5. Required: all outputs return to reset values, rdy=1 after release, and a rerun of 8 vectors gives vec_cnt=8.
- CNT_W=2 with 5 failing vectors. Required: err_cnt stays at 3 and vec_cnt wraps to 1.
- WIDTH=4, a=15, b=1, cin=1, DUT returning {cout,sum}=5'b10001. Required: pass=1. Then vld asserted in DONE. Required: ignored, with vec_cnt unchanged.
